csa_accumulator: RTL and testbench

Sequential multi-operand adder built on the W-bit carry-save row. It accepts a stream of W-bit operands, one per cycle, and holds the running total in carry-save form (sum and carry registers). On the last operand of a frame, it resolves the pair to a binary result by iterating carry propagation, one step per cycle. Its first user is the neighbour-count path of the game-of-life cell array (8 neighbours per frame); the block is generic in width and frame length.

---
 rtl/csa_pkg.sv | 15 +
 rtl/carry_save_adder.sv | 22 ++
 rtl/full_adder.sv | 13 +
 rtl/csa_accumulator.sv | 110 +++++++++++
 tb/tb_csa_accumulator.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared types and helpers for the carry-save accumulator
package csa_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Counter width able to hold the value n itself.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/carry_save_adder.sv
// rtl/carry_save_adder.sv - W-bit carry-save row of independent full adders
module carry_save_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] s,
    output logic [W-1:0] co
);

    for (genvar i = 0; i < W; i++) begin : g_fa
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (co[i])
        );
    end

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - multi-operand accumulator in carry-save form with iterative resolve
module csa_accumulator
    import csa_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_last,
    input  logic [W-1:0] A,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] S,
    output logic         Ovf
);

    localparam int CW = cnt_w(N);

    state_t        state, state_nxt;
    logic [W-1:0]  sr, cr;
    logic [W-1:0]  csa_s, csa_co, res_c;
    logic [CW-1:0] cnt, cnt_inc;
    logic          ovf;
    logic          accept, frame_end, cr_zero;

    carry_save_adder #(.W(W)) u_csa (
        .a  (sr),
        .b  (cr),
        .c  (A),
        .s  (csa_s),
        .co (csa_co)
    );

    assign accept    = in_valid && (state == ACCUM);
    assign cnt_inc   = cnt + CW'(1);
    assign frame_end = accept && (in_last || (cnt_inc == CW'(N)));
    assign res_c     = sr & cr;
    assign cr_zero   = (cr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ACCUM:   if (frame_end) state_nxt = RESOLVE;
            RESOLVE: if (cr_zero)   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == DONE);
    end

    // Carries shifted out of the MSB are folded into the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cr  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (accept) begin
                        sr  <= csa_s;
                        cr  <= {csa_co[W-2:0], 1'b0};
                        ovf <= ovf | csa_co[W-1];
                        cnt <= frame_end ? '0 : cnt_inc;
                    end
                end
                RESOLVE: begin
                    if (!cr_zero) begin
                        sr  <= sr ^ cr;
                        cr  <= {res_c[W-2:0], 1'b0};
                        ovf <= ovf | res_c[W-1];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        sr  <= '0;
                        cr  <= '0;
                        ovf <= 1'b0;
                    end
                end
                default: begin
                    sr  <= '0;
                    cr  <= '0;
                    cnt <= '0;
                    ovf <= 1'b0;
                end
            endcase
        end
    end

    assign S   = sr;
    assign Ovf = ovf;

endmodule

// File: tb/tb_csa_accumulator.sv
// tb/tb_csa_accumulator.sv - directed and random checks of 4-bit and 8-bit accumulators in lockstep
module tb_csa_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_last, out_ready;
    logic [7:0] a8;
    logic [3:0] a4;
    logic       rdy4, rdy8, vld4, vld8, ovf4, ovf8;
    logic [3:0] s4;
    logic [7:0] s8;

    int n_cmp = 0;
    int n_bad = 0;
    int sum4, sum8, beats;

    assign a4 = a8[3:0];

    always #5 clk = ~clk;

    csa_accumulator #(.W(4), .N(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4),
        .in_last(in_last), .A(a4), .out_valid(vld4), .out_ready(out_ready),
        .S(s4), .Ovf(ovf4)
    );

    csa_accumulator #(.W(8), .N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
        .in_last(in_last), .A(a8), .out_valid(vld8), .out_ready(out_ready),
        .S(s8), .Ovf(ovf8)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one operand; returns #1 after the accepting edge.
    task automatic push(input logic [7:0] op, input logic last);
        int guard = 0;
        in_valid = 1'b1;
        a8       = op;
        in_last  = last;
        while (!(rdy4 && rdy8) && guard < 50) begin
            step();
            guard++;
        end
        check_eq("push_ready_timeout", (guard < 50), 1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        a8       = 8'h00;
        sum4 += int'(op[3:0]);
        sum8 += int'(op);
        beats++;
    endtask

    // Waits for both results, optionally stalls the consumer, then takes them.
    task automatic take(input string tag, input int hold);
        int cyc = 0, lat4 = -1, lat8 = -1;
        logic [3:0] e4;
        logic [7:0] e8;
        e4 = 4'(sum4);
        e8 = 8'(sum8);
        while (!(vld4 && vld8) && cyc < 40) begin
            if (vld4 && lat4 < 0) lat4 = cyc;
            if (vld8 && lat8 < 0) lat8 = cyc;
            step();
            cyc++;
        end
        if (lat4 < 0) lat4 = cyc;
        if (lat8 < 0) lat8 = cyc;
        check_eq({tag, "_lat4"}, (lat4 <= 6), 1);
        check_eq({tag, "_lat8"}, (lat8 <= 10), 1);
        for (int h = 0; h < hold; h++) begin
            check_eq({tag, "_hold_s4"}, s4, e4);
            check_eq({tag, "_hold_s8"}, s8, e8);
            check_eq({tag, "_hold_rdy"}, {rdy4, rdy8, vld4, vld8}, 4'b0011);
            step();
        end
        check_eq({tag, "_s4"}, s4, e4);
        check_eq({tag, "_ovf4"}, ovf4, (sum4 >= 16));
        check_eq({tag, "_s8"}, s8, e8);
        check_eq({tag, "_ovf8"}, ovf8, (sum8 >= 256));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq({tag, "_back_accum"}, {rdy4, rdy8, vld4, vld8}, 4'b1100);
        sum4  = 0;
        sum8  = 0;
        beats = 0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; a8 = 8'h00;
        sum4 = 0; sum8 = 0; beats = 0;
        #12;
        check_eq("rst_state4", {rdy4, vld4, s4, ovf4}, {1'b1, 1'b0, 4'h0, 1'b0});
        check_eq("rst_state8", {rdy8, vld8, s8, ovf8}, {1'b1, 1'b0, 8'h00, 1'b0});
        rst_n = 1'b1;
        step();

        // 3 + 5 + 7 = 15, consumer stalled five cycles
        push(8'd3, 1'b0); push(8'd5, 1'b0); push(8'd7, 1'b1);
        take("f357", 5);

        // 9 + 9 overflows 4 bits; next frame must start with a clear flag
        push(8'd9, 1'b0); push(8'd9, 1'b1);
        take("f99", 0);
        push(8'd1, 1'b1);
        take("f1", 0);

        // in_last with in_valid low is ignored
        in_last = 1'b1; step(); step(); in_last = 1'b0;
        push(8'd6, 1'b0); push(8'd2, 1'b1);
        take("ignlast", 0);

        // eight beats without in_last close the frame; the 9th starts a new one
        for (int i = 0; i < 8; i++) push(8'd1, 1'b0);
        take("eight", 0);
        push(8'd1, 1'b1);
        take("ninth", 0);

        // large operands for long resolve
        push(8'hFF, 1'b0); push(8'h01, 1'b0); push(8'hFF, 1'b1);
        take("carry", 0);

        // reset during resolve discards the frame immediately
        push(8'd200, 1'b0); push(8'd100, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst", {rdy4, rdy8, vld4, vld8, s8, ovf8}, {4'b1100, 8'h00, 1'b0});
        step();
        rst_n = 1'b1;
        sum4 = 0; sum8 = 0; beats = 0;
        step();
        push(8'd4, 1'b0); push(8'd4, 1'b1);
        take("after_rst", 0);

        // random frames with gaps
        for (int f = 0; f < 8; f++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int b = 0; b < len; b++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    in_last = 1'($urandom_range(0, 1));
                    step();
                end
                in_last = 1'b0;
                push(8'($urandom_range(0, 255)), (b == len - 1) && (len < 8 || f[0]));
            end
            take("rand", $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
